servo_motion_scheduler: RTL and testbench
=========================================

Name: servo_motion_scheduler

Overview:
Sits between inverse_kinematics and the two servo pwm instances. Captures new shoulder/elbow pulse-width targets and slews the commanded pulse widths toward them at a bounded rate, one step per tick. Sequences the shared servo enable: enable asserts while moving, holds for a timeout after arrival, then drops. Replaces the free-running pwm_enable timeout, so arm motion is rate-limited and both joints are scheduled from one controller.

Parameters:
WIDTH, 24, pulse-width bus width (clock cycles)
MIN_PULSE, 100000, lowest legal pulse width (1 ms at 100 MHz)
MAX_PULSE, 200000, highest legal pulse width (2 ms)
HOME_PULSE, 150000, commanded width after reset
STEP, 100, maximum change per axis per tick
TICK_CYCLES, 100000, clocks per slew tick (1 ms)
HOLD_CYCLES, 140000000, clocks enable stays high after arrival

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
target_shoulder  input  WIDTH  requested shoulder pulse width
target_elbow  input  WIDTH  requested elbow pulse width
target_valid  input  1  single-cycle strobe; capture both targets
cmd_shoulder  output  WIDTH  commanded shoulder width to pwm
cmd_elbow  output  WIDTH  commanded elbow width to pwm
pwm_en  output  1  shared servo enable
busy  output  1  high in MOVE
settled  output  1  high in HOLD

Behaviour:
- Reset (synchronous, clk edge with reset=1): cmd_shoulder=cmd_elbow=HOME_PULSE, registered targets=HOME_PULSE, tick counter=0, hold counter=0, state=IDLE, pwm_en=0, busy=0, settled=0. Reset mid-move abandons the move immediately.
- Capture: on target_valid, each target is clamped to [MIN_PULSE, MAX_PULSE] and registered. Capture is accepted in every state, and the last strobe wins.
- Tick: the counter runs 0..TICK_CYCLES-1 continuously, independent of state. tick=1 for the one cycle where count==TICK_CYCLES-1.
- Per-axis step on tick in MOVE: diff = target - cmd. If |diff| <= STEP, cmd = target; otherwise cmd moves by ±STEP toward the target. Arithmetic is unsigned with an explicit compare, so there is no wrap below 0 or above 2^WIDTH-1.
- Axes step independently. An axis that has arrived holds its value while the other keeps moving.
- States (all outputs registered; state change is visible the cycle after the causing edge):
  IDLE: pwm_en=0. On target_valid go to MOVE.
  MOVE: pwm_en=1, busy=1. Both cmd equal to targets (evaluated each cycle) -> HOLD, clear hold counter.
  HOLD: pwm_en=1, settled=1. Hold counter increments each cycle; at HOLD_CYCLES-1 go to IDLE. On target_valid go to MOVE.
- target_valid with targets equal to current cmd: enter MOVE, then HOLD on the following cycle. This re-arms the enable with no motion.
- target_valid coinciding with tick: the step in that cycle uses the previously registered targets. The new targets apply from the next tick.
- Latency: the first cmd change occurs at the first tick after capture, between 1 and TICK_CYCLES cycles later.
- cmd values always stay within [MIN_PULSE, MAX_PULSE] provided HOME_PULSE is within that range.

Decomposition:
- Package servo_pkg: state enum (IDLE, MOVE, HOLD), default pulse constants (MIN/MAX/HOME), WIDTH default.
- Sub-module slew_axis, instantiated twice. It takes clk, reset, tick, load, target, enable and produces cmd and arrived, and contains the clamp and step logic.
- The top holds the tick counter, hold counter and FSM.

Test Plan:
(Bench overrides: MIN=100, MAX=200, HOME=150, STEP=10, TICK_CYCLES=4, HOLD_CYCLES=20.)
- Reset then idle 50 cycles -> cmd_shoulder=cmd_elbow=150, pwm_en=0, busy=0 throughout.
- target_valid with shoulder=180, elbow=130 -> busy and pwm_en high next cycle. Shoulder steps 160, 170, 180; elbow steps 140, 130 then holds. settled after shoulder reaches 180. pwm_en drops 20 cycles after HOLD entry and state returns to IDLE.
- Out-of-range targets shoulder=250, elbow=20 -> slews to 200 and 100. No cmd value outside [100, 200] is ever produced.
- Non-multiple step: target shoulder=155 from 150 -> single tick to 155, then HOLD.
- Retarget mid-move (shoulder 150→200, new target 160 when cmd=180) -> next tick 170, then 160. busy stays high, with no HOLD in between.
- Reset asserted while cmd=170 in MOVE -> next cycle cmd=150, pwm_en=0, IDLE. target_valid coinciding with tick uses the old target for that step, and the next tick applies the new target.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and default pulse constants for the servo motion scheduler.
// Pulse values are in clock cycles at 100 MHz.
package servo_pkg;

  localparam int unsigned SERVO_WIDTH      = 32'd24;
  localparam int unsigned SERVO_MIN_PULSE  = 32'd100000;
  localparam int unsigned SERVO_MAX_PULSE  = 32'd200000;
  localparam int unsigned SERVO_HOME_PULSE = 32'd150000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_HOLD = 2'd2
  } servo_state_e;

endpackage

// File: rtl/slew_axis.sv
// One servo axis: clamps and registers a new target, then slews the commanded
// pulse width toward it by at most STEP per enabled tick.
module slew_axis
  import servo_pkg::*;
#(
  parameter int unsigned WIDTH      = SERVO_WIDTH,
  parameter int unsigned MIN_PULSE  = SERVO_MIN_PULSE,
  parameter int unsigned MAX_PULSE  = SERVO_MAX_PULSE,
  parameter int unsigned HOME_PULSE = SERVO_HOME_PULSE,
  parameter int unsigned STEP       = 32'd100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  input  logic             enable,
  output logic [WIDTH-1:0] cmd,
  output logic             arrived
);

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_PULSE);
  localparam logic [WIDTH-1:0] HOME_W = WIDTH'(HOME_PULSE);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] target_r;
  logic [WIDTH-1:0] cmd_r;
  logic [WIDTH-1:0] next_cmd_s;

  function automatic logic [WIDTH-1:0] clamp_pulse(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (value < MIN_W) begin
      result = MIN_W;
    end else if (value > MAX_W) begin
      result = MAX_W;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Next commanded width: one bounded step toward the target, direction chosen
  // by compare so the unsigned subtraction never wraps.
  always_comb begin
    next_cmd_s = cmd_r;
    if (cmd_r < target_r) begin
      if ((target_r - cmd_r) <= STEP_W) begin
        next_cmd_s = target_r;
      end else begin
        next_cmd_s = cmd_r + STEP_W;
      end
    end else if (cmd_r > target_r) begin
      if ((cmd_r - target_r) <= STEP_W) begin
        next_cmd_s = target_r;
      end else begin
        next_cmd_s = cmd_r - STEP_W;
      end
    end else begin
      next_cmd_s = cmd_r;
    end
  end

  // Target capture and commanded-width register; a step issued on the same
  // edge as a capture still uses the previously registered target.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r <= HOME_W;
      cmd_r    <= HOME_W;
    end else begin
      if (load) begin
        target_r <= clamp_pulse(target);
      end
      if (enable && tick) begin
        cmd_r <= next_cmd_s;
      end
    end
  end

  assign cmd     = cmd_r;
  assign arrived = (cmd_r == target_r);

endmodule

// File: rtl/servo_motion_scheduler.sv
// Rate-limited shoulder/elbow pulse-width scheduler with a shared servo enable
// that stays on while moving and for a hold window after arrival.
module servo_motion_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned WIDTH       = SERVO_WIDTH,
  parameter int unsigned MIN_PULSE   = SERVO_MIN_PULSE,
  parameter int unsigned MAX_PULSE   = SERVO_MAX_PULSE,
  parameter int unsigned HOME_PULSE  = SERVO_HOME_PULSE,
  parameter int unsigned STEP        = 32'd100,
  parameter int unsigned TICK_CYCLES = 32'd100000,
  parameter int unsigned HOLD_CYCLES = 32'd140000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target_shoulder,
  input  logic [WIDTH-1:0] target_elbow,
  input  logic             target_valid,
  output logic [WIDTH-1:0] cmd_shoulder,
  output logic [WIDTH-1:0] cmd_elbow,
  output logic             pwm_en,
  output logic             busy,
  output logic             settled
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 32'd1) ? $clog2(TICK_CYCLES) : 32'd1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 32'd1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);

  servo_state_e      state_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              tick_s;
  logic              move_en_s;
  logic              sh_arrived_s;
  logic              el_arrived_s;
  logic              pwm_en_r;
  logic              busy_r;
  logic              settled_r;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign move_en_s = (state_r == ST_MOVE);

  // Free-running slew tick, independent of scheduler state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  slew_axis #(
    .WIDTH     (WIDTH),
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .HOME_PULSE(HOME_PULSE),
    .STEP      (STEP)
  ) u_shoulder (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_s),
    .load   (target_valid),
    .target (target_shoulder),
    .enable (move_en_s),
    .cmd    (cmd_shoulder),
    .arrived(sh_arrived_s)
  );

  slew_axis #(
    .WIDTH     (WIDTH),
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .HOME_PULSE(HOME_PULSE),
    .STEP      (STEP)
  ) u_elbow (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_s),
    .load   (target_valid),
    .target (target_elbow),
    .enable (move_en_s),
    .cmd    (cmd_elbow),
    .arrived(el_arrived_s)
  );

  // Scheduler FSM with registered enable/status flags. A fresh strobe in MOVE
  // keeps us moving so HOLD is never entered against a stale target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      pwm_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      settled_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (target_valid) begin
            state_r   <= ST_MOVE;
            pwm_en_r  <= 1'b1;
            busy_r    <= 1'b1;
            settled_r <= 1'b0;
          end
        end
        ST_MOVE: begin
          if (!target_valid && sh_arrived_s && el_arrived_s) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= '0;
            pwm_en_r   <= 1'b1;
            busy_r     <= 1'b0;
            settled_r  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (target_valid) begin
            state_r   <= ST_MOVE;
            pwm_en_r  <= 1'b1;
            busy_r    <= 1'b1;
            settled_r <= 1'b0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r   <= ST_IDLE;
            pwm_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            settled_r <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hold_cnt_r <= '0;
          pwm_en_r   <= 1'b0;
          busy_r     <= 1'b0;
          settled_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_en  = pwm_en_r;
  assign busy    = busy_r;
  assign settled = settled_r;

endmodule

// File: tb/tb_servo_motion_scheduler.sv
// Self-checking bench for servo_motion_scheduler: directed scenarios plus a
// randomized run, all compared against an integer behavioural model.
module tb_servo_motion_scheduler;

  localparam int W     = 24;
  localparam int MINP  = 100;
  localparam int MAXP  = 200;
  localparam int HOMEP = 150;
  localparam int STEPP = 10;
  localparam int TICKC = 4;
  localparam int HOLDC = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] target_shoulder = '0;
  logic [W-1:0] target_elbow = '0;
  logic         target_valid = 1'b0;
  logic [W-1:0] cmd_shoulder;
  logic [W-1:0] cmd_elbow;
  logic         pwm_en;
  logic         busy;
  logic         settled;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: plain integers, phase 0=idle 1=moving 2=holding.
  int m_cmd[2];
  int m_tgt[2];
  int m_phase;
  int m_tcnt;
  int m_hcnt;

  servo_motion_scheduler #(
    .WIDTH(W), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .HOME_PULSE(HOMEP),
    .STEP(STEPP), .TICK_CYCLES(TICKC), .HOLD_CYCLES(HOLDC)
  ) dut (
    .clk(clk), .reset(reset),
    .target_shoulder(target_shoulder), .target_elbow(target_elbow),
    .target_valid(target_valid),
    .cmd_shoulder(cmd_shoulder), .cmd_elbow(cmd_elbow),
    .pwm_en(pwm_en), .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  wire [2*W+2:0] dut_vec = {cmd_shoulder, cmd_elbow, pwm_en, busy, settled};

  function automatic int clampi(input int v);
    return (v < MINP) ? MINP : ((v > MAXP) ? MAXP : v);
  endfunction

  function automatic int step_toward(input int c, input int t);
    if (t - c > STEPP) return c + STEPP;
    if (c - t > STEPP) return c - STEPP;
    return t;
  endfunction

  function automatic logic [2*W+2:0] exp_vec();
    return {W'(m_cmd[0]), W'(m_cmd[1]), (m_phase != 0), (m_phase == 1), (m_phase == 2)};
  endfunction

  task automatic model_update();
    bit tk;
    bit arr;
    int nph;
    if (reset) begin
      m_cmd[0] = HOMEP; m_cmd[1] = HOMEP;
      m_tgt[0] = HOMEP; m_tgt[1] = HOMEP;
      m_phase = 0; m_tcnt = 0; m_hcnt = 0;
    end else begin
      tk  = (m_tcnt == TICKC - 1);
      arr = (m_cmd[0] == m_tgt[0]) && (m_cmd[1] == m_tgt[1]);
      if (m_phase == 1 && tk) begin
        for (int i = 0; i < 2; i++) m_cmd[i] = step_toward(m_cmd[i], m_tgt[i]);
      end
      nph = m_phase;
      if (m_phase == 0) begin
        if (target_valid) nph = 1;
      end else if (m_phase == 1) begin
        if (!target_valid && arr) begin nph = 2; m_hcnt = 0; end
      end else begin
        if (target_valid) nph = 1;
        else if (m_hcnt == HOLDC - 1) nph = 0;
        else m_hcnt++;
      end
      m_phase = nph;
      m_tcnt = (m_tcnt + 1) % TICKC;
      if (target_valid) begin
        m_tgt[0] = clampi(int'(target_shoulder));
        m_tgt[1] = clampi(int'(target_elbow));
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_clk();
    reset = 1'b0;
  endtask

  task automatic strobe(input int sh, input int el);
    target_shoulder = W'(sh);
    target_elbow    = W'(el);
    target_valid    = 1'b1;
    tick_clk();
    target_valid    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_clk();
    tick_clk();
    n_tests++;
    if (dut_vec !== {W'(HOMEP), W'(HOMEP), 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, {W'(HOMEP), W'(HOMEP), 3'b000});
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== {W'(HOMEP), W'(HOMEP), 3'b000}) begin
        n_fail++;
        $display("FAIL idle_hold cyc %0d: got %h expected %h", i, dut_vec, {W'(HOMEP), W'(HOMEP), 3'b000});
      end
    end
  endtask

  task automatic test_basic_move();
    int sh_seq[$];
    int el_seq[$];
    int last_sh, last_el, hold_cyc;
    bit done;
    do_reset();
    last_sh = HOMEP; last_el = HOMEP; hold_cyc = 0; done = 1'b0;
    strobe(180, 130);
    n_tests++;
    if ({pwm_en, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_start: got en/busy=%b%b expected 11", pwm_en, busy);
    end
    for (int i = 0; i < 200 && !done; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (int'(cmd_shoulder) != last_sh) begin last_sh = int'(cmd_shoulder); sh_seq.push_back(last_sh); end
      if (int'(cmd_elbow) != last_el) begin last_el = int'(cmd_elbow); el_seq.push_back(last_el); end
      if (settled === 1'b1) hold_cyc++;
      if (m_phase == 0) done = 1'b1;
    end
    n_tests++;
    if (!done || sh_seq.size() != 3 || sh_seq[0] != 160 || sh_seq[1] != 170 || sh_seq[2] != 180) begin
      n_fail++;
      $display("FAIL basic_shoulder_seq: got %0d steps ending %0d, expected 160,170,180", sh_seq.size(), last_sh);
    end
    n_tests++;
    if (el_seq.size() != 2 || el_seq[0] != 140 || el_seq[1] != 130) begin
      n_fail++;
      $display("FAIL basic_elbow_seq: got %0d steps ending %0d, expected 140,130", el_seq.size(), last_el);
    end
    n_tests++;
    if (hold_cyc != HOLDC || pwm_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold_len: got %0d settled cycles en=%b, expected %0d en=0", hold_cyc, pwm_en, HOLDC);
    end
  endtask

  task automatic test_rearm();
    do_reset();
    strobe(HOMEP, HOMEP);
    n_tests++;
    if ({pwm_en, busy, settled} !== 3'b110) begin
      n_fail++;
      $display("FAIL rearm_move: got %b expected 110", {pwm_en, busy, settled});
    end
    tick_clk();
    n_tests++;
    if ({pwm_en, busy, settled} !== 3'b101 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL rearm_hold: got %b expected 101", {pwm_en, busy, settled});
    end
  endtask

  task automatic test_clamp();
    bit done;
    done = 1'b0;
    do_reset();
    strobe(250, 20);
    for (int i = 0; i < 200 && !done; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== exp_vec() || cmd_shoulder < W'(MINP) || cmd_shoulder > W'(MAXP) ||
          cmd_elbow < W'(MINP) || cmd_elbow > W'(MAXP)) begin
        n_fail++;
        $display("FAIL clamp_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (m_phase == 2) done = 1'b1;
    end
    n_tests++;
    if (!done || cmd_shoulder !== W'(200) || cmd_elbow !== W'(100)) begin
      n_fail++;
      $display("FAIL clamp_final: got sh=%0d el=%0d expected 200/100", cmd_shoulder, cmd_elbow);
    end
  endtask

  task automatic test_non_multiple();
    int changes;
    int last_sh;
    bit done;
    changes = 0; last_sh = HOMEP; done = 1'b0;
    do_reset();
    strobe(155, HOMEP);
    for (int i = 0; i < 40 && !done; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL nonmult_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (int'(cmd_shoulder) != last_sh) begin changes++; last_sh = int'(cmd_shoulder); end
      if (settled === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done || changes != 1 || cmd_shoulder !== W'(155)) begin
      n_fail++;
      $display("FAIL nonmult_final: got %0d changes sh=%0d settled=%b expected 1 change to 155", changes, cmd_shoulder, settled);
    end
  endtask

  task automatic test_retarget();
    int seq[$];
    int last_sh;
    bit found;
    bit done;
    found = 1'b0; done = 1'b0;
    do_reset();
    strobe(200, HOMEP);
    for (int i = 0; i < 40 && !found; i++) begin
      tick_clk();
      if (cmd_shoulder === W'(180)) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL retarget_reach180: got sh=%0d expected 180 within 40 cycles", cmd_shoulder);
    end
    last_sh = int'(cmd_shoulder);
    strobe(160, HOMEP);
    for (int i = 0; i < 40 && !done; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== exp_vec() || (cmd_shoulder !== W'(160) && busy !== 1'b1)) begin
        n_fail++;
        $display("FAIL retarget_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (int'(cmd_shoulder) != last_sh) begin last_sh = int'(cmd_shoulder); seq.push_back(last_sh); end
      if (settled === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done || seq.size() != 2 || seq[0] != 170 || seq[1] != 160) begin
      n_fail++;
      $display("FAIL retarget_seq: got %0d steps ending %0d expected 170,160", seq.size(), last_sh);
    end
  endtask

  task automatic test_tick_coincide();
    int seq[$];
    int last_sh;
    bit found;
    bit done;
    found = 1'b0; done = 1'b0;
    do_reset();
    strobe(200, HOMEP);
    for (int i = 0; i < 40 && !found; i++) begin
      tick_clk();
      if (cmd_shoulder === W'(160) && m_tcnt == TICKC - 1) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL coincide_setup: got sh=%0d expected 160 before a tick", cmd_shoulder);
    end
    strobe(HOMEP, HOMEP);
    n_tests++;
    if (cmd_shoulder !== W'(170)) begin
      n_fail++;
      $display("FAIL coincide_old_target: got sh=%0d expected 170", cmd_shoulder);
    end
    last_sh = int'(cmd_shoulder);
    for (int i = 0; i < 40 && !done; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL coincide_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (int'(cmd_shoulder) != last_sh) begin last_sh = int'(cmd_shoulder); seq.push_back(last_sh); end
      if (settled === 1'b1) done = 1'b1;
    end
    n_tests++;
    if (!done || seq.size() != 2 || seq[0] != 160 || seq[1] != 150) begin
      n_fail++;
      $display("FAIL coincide_seq: got %0d steps ending %0d expected 160,150", seq.size(), last_sh);
    end
  endtask

  task automatic test_reset_mid_move();
    bit found;
    found = 1'b0;
    do_reset();
    strobe(200, 120);
    for (int i = 0; i < 40 && !found; i++) begin
      tick_clk();
      if (cmd_shoulder === W'(170)) found = 1'b1;
    end
    n_tests++;
    if (!found || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: got sh=%0d busy=%b expected 170 busy=1", cmd_shoulder, busy);
    end
    reset = 1'b1;
    tick_clk();
    reset = 1'b0;
    n_tests++;
    if (dut_vec !== {W'(HOMEP), W'(HOMEP), 3'b000}) begin
      n_fail++;
      $display("FAIL midreset_state: got %h expected %h", dut_vec, {W'(HOMEP), W'(HOMEP), 3'b000});
    end
    for (int i = 0; i < 12; i++) begin
      tick_clk();
      n_tests++;
      if (dut_vec !== {W'(HOMEP), W'(HOMEP), 3'b000}) begin
        n_fail++;
        $display("FAIL midreset_idle %0d: got %h", i, dut_vec);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      target_valid = ($urandom_range(0, 14) == 0);
      target_shoulder = W'($urandom_range(0, 300));
      target_elbow = W'($urandom_range(0, 300));
      tick_clk();
      n_tests++;
      if (dut_vec !== exp_vec() || cmd_shoulder < W'(MINP) || cmd_shoulder > W'(MAXP) ||
          cmd_elbow < W'(MINP) || cmd_elbow > W'(MAXP)) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    reset = 1'b0;
    target_valid = 1'b0;
  endtask

  initial begin
    m_cmd[0] = HOMEP; m_cmd[1] = HOMEP;
    m_tgt[0] = HOMEP; m_tgt[1] = HOMEP;
    m_phase = 0; m_tcnt = 0; m_hcnt = 0;
    @(negedge clk);
    test_reset();
    test_basic_move();
    test_rearm();
    test_clamp();
    test_non_multiple();
    test_retarget();
    test_tick_coincide();
    test_reset_mid_move();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
